// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// the bit-period divisor helper used by both the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  // Cycles per bit, truncated; the caller must guarantee the result is >= 2.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the buffered UART transmitter: valid/ready handshake
// from a producer (master) into the transmit FIFO (slave).
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic                      wr_valid;
  logic [UART_DATA_BITS-1:0] wr_data;
  logic                      wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while
// empty are ignored, so the caller only has to gate on full/empty if it cares.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is intentionally not reset; pointers and count alone define
  // which entries are valid, and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO through a valid/ready
// port and are shifted out LSB first, back-to-back when more are queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_fifo_if.slave          wr,
  output logic                   uart_tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int BW   = $clog2(DIV);
  localparam int BITW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(DIV - 1);
  localparam logic [BITW-1:0] LAST_DATA = BITW'(UART_DATA_BITS - 1);
  localparam logic [BITW-1:0] LAST_STOP = BITW'(UART_STOP_BITS - 1);

  tx_state_t                 st, st_next;
  logic [BW-1:0]             baud_cnt, baud_next;
  logic [BITW-1:0]           bit_cnt, bit_next;
  logic [UART_DATA_BITS-1:0] shreg, shreg_next;
  logic                      tx_next;
  logic                      bit_end;
  logic                      pop;
  logic                      push;
  logic                      full;
  logic                      empty;
  logic [UART_DATA_BITS-1:0] fifo_data;

  assign push        = wr.wr_valid && !full;
  assign wr.wr_ready = !full;
  assign busy        = (st != IDLE) || (count != '0);
  assign bit_end     = (baud_cnt == BAUD_LAST);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr.wr_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // NOTE: every signal below gets a default before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    st_next    = st;
    baud_next  = '0;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    tx_next    = uart_tx;
    pop        = 1'b0;
    if (st != IDLE && !bit_end) baud_next = baud_cnt + 1'b1;

    case (st)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = fifo_data;
          tx_next    = 1'b0;
          bit_next   = '0;
          st_next    = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_next = shreg[0];
          st_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            tx_next  = 1'b1;
            bit_next = '0;
            st_next  = STOP;
          end else begin
            shreg_next = shreg >> 1;
            tx_next    = shreg[1];
            bit_next   = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        // Popping straight from STOP keeps queued frames gap-free.
        if (bit_end) begin
          if (bit_cnt != LAST_STOP) begin
            bit_next = bit_cnt + 1'b1;
          end else if (!empty) begin
            pop        = 1'b1;
            shreg_next = fifo_data;
            tx_next    = 1'b0;
            bit_next   = '0;
            st_next    = START;
          end else begin
            st_next = IDLE;
          end
        end
      end
      default: st_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop captures
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      st       <= st_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_next;
      shreg    <= shreg_next;
      uart_tx  <= tx_next;
      if (wr.wr_valid && full) overflow <= 1'b1;
    end
  end

endmodule
